// File: rtl/or1200_keccak_pkg.sv
// Shared definitions for the l.cust5 Keccak execution unit: op encodings,
// FSM states, default block geometry and pad10*1 constants.
package or1200_keccak_pkg;

    localparam int RATE_WORDS_DEF   = 34;
    localparam int DIGEST_WORDS_DEF = 16;

    // pad10*1: first pad bit lands in the low bit of the byte after the
    // message, last pad bit in the top bit of the final byte of the block
    localparam logic [7:0] PAD_FIRST_BYTE = 8'h01;
    localparam logic [7:0] PAD_LAST_BYTE  = 8'h80;

    typedef enum logic [4:0] {
        OP_INIT   = 5'b00000,
        OP_END    = 5'b00001,
        OP_MIDDLE = 5'b00010,
        OP_START  = 5'b00100,
        OP_STORE  = 5'b01000
    } cust_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ABSORB,
        ST_FIRE,
        ST_WAIT,
        ST_PAD,
        ST_FIRE_LAST,
        ST_WAIT_LAST,
        ST_DONE
    } kstate_e;

endpackage

// File: rtl/or1200_keccak_padbuf.sv
// Rate-block buffer: word write port, word counter and pad10*1 insertion.
module or1200_keccak_padbuf
    import or1200_keccak_pkg::*;
#(
    parameter int RATE_WORDS = RATE_WORDS_DEF,
    parameter int CNT_W      = $clog2(RATE_WORDS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_i,
    input  logic                    cnt_clr_i,
    input  logic                    wr_i,
    input  logic [31:0]             wdata_i,
    input  logic                    pad_i,
    output logic [CNT_W-1:0]        wcnt_o,
    output logic [32*RATE_WORDS-1:0] block_o
);

    logic [RATE_WORDS-1:0][31:0] buf_q, buf_d;
    logic [CNT_W-1:0]            wcnt_q, wcnt_d;

    // Clear happens before the write so a restart lands its word in slot 0.
    always_comb begin
        buf_d  = buf_q;
        wcnt_d = wcnt_q;
        if (clr_i) begin
            buf_d  = '0;
            wcnt_d = '0;
        end
        if (cnt_clr_i) begin
            wcnt_d = '0;
        end
        if (wr_i) begin
            for (int i = 0; i < RATE_WORDS; i++) begin
                if (wcnt_d == CNT_W'(i)) buf_d[i] = wdata_i;
            end
            wcnt_d = wcnt_d + 1'b1;
        end
        if (pad_i) begin
            for (int i = 0; i < RATE_WORDS; i++) begin
                if (wcnt_q == CNT_W'(i)) buf_d[i][7:0] = buf_d[i][7:0] ^ PAD_FIRST_BYTE;
            end
            buf_d[RATE_WORDS-1][31:24] = buf_d[RATE_WORDS-1][31:24] ^ PAD_LAST_BYTE;
        end
    end

    // Buffer and counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_q  <= '0;
            wcnt_q <= '0;
        end else begin
            buf_q  <= buf_d;
            wcnt_q <= wcnt_d;
        end
    end

    assign wcnt_o  = wcnt_q;
    assign block_o = buf_q;

endmodule

// File: rtl/or1200_keccak_cust5_unit.sv
// l.cust5 execution unit: decodes cust5 ops, sequences rate blocks into the
// Keccak core over start/done, stalls the pipeline while busy and returns
// digest words on store.
module or1200_keccak_cust5_unit
    import or1200_keccak_pkg::*;
#(
    parameter int RATE_WORDS   = RATE_WORDS_DEF,
    parameter int DIGEST_WORDS = DIGEST_WORDS_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cust_valid,
    input  logic [4:0]                cust_op,
    input  logic [5:0]                cust_idx,
    input  logic [31:0]               cust_opa,
    output logic                      cust_stall,
    output logic                      cust_rf_we,
    output logic [31:0]               cust_result,
    output logic                      core_start,
    output logic                      core_init,
    output logic [32*RATE_WORDS-1:0]  core_block,
    input  logic                      core_done,
    input  logic [32*DIGEST_WORDS-1:0] core_digest
);

    localparam int               CNT_W     = $clog2(RATE_WORDS + 1);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(RATE_WORDS - 1);

    kstate_e          state_q, state_d;
    logic             first_blk_q, first_blk_d;
    logic             dig_valid_q, dig_valid_d;
    logic             pad_pend_q, pad_pend_d;
    logic             buf_clr, cnt_clr, buf_wr, buf_pad;
    logic [CNT_W-1:0] wcnt;
    logic             op_init, op_start, op_middle, op_end, op_store, op_known;
    logic [31:0]      dig_word;

    or1200_keccak_padbuf #(
        .RATE_WORDS (RATE_WORDS),
        .CNT_W      (CNT_W)
    ) u_padbuf (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (buf_clr),
        .cnt_clr_i (cnt_clr),
        .wr_i      (buf_wr),
        .wdata_i   (cust_opa),
        .pad_i     (buf_pad),
        .wcnt_o    (wcnt),
        .block_o   (core_block)
    );

    // Decode the presented op; unknown encodings decode to nothing.
    always_comb begin
        op_init   = 1'b0;
        op_start  = 1'b0;
        op_middle = 1'b0;
        op_end    = 1'b0;
        op_store  = 1'b0;
        if (cust_valid) begin
            case (cust_op_e'(cust_op))
                OP_INIT:   op_init   = 1'b1;
                OP_START:  op_start  = 1'b1;
                OP_MIDDLE: op_middle = 1'b1;
                OP_END:    op_end    = 1'b1;
                OP_STORE:  op_store  = 1'b1;
                default:   ;
            endcase
        end
        op_known = op_init | op_start | op_middle | op_end | op_store;
    end

    // Digest word select; indices past the digest read as zero.
    always_comb begin
        dig_word = '0;
        for (int i = 0; i < DIGEST_WORDS; i++) begin
            if (cust_idx == 6'(i)) dig_word = core_digest[i*32 +: 32];
        end
    end

    // Next-state, buffer control and pipeline handshake.
    always_comb begin
        state_d     = state_q;
        first_blk_d = first_blk_q;
        dig_valid_d = dig_valid_q;
        pad_pend_d  = pad_pend_q;
        buf_clr     = 1'b0;
        cnt_clr     = 1'b0;
        buf_wr      = 1'b0;
        buf_pad     = 1'b0;
        cust_stall  = 1'b0;
        cust_rf_we  = 1'b0;
        cust_result = '0;
        core_start  = 1'b0;
        core_init   = 1'b0;

        // Once core_start has fired the core is committed, so init is only
        // honoured where no permutation is in flight.
        if (op_init && (state_q inside {ST_IDLE, ST_ABSORB, ST_DONE, ST_PAD})) begin
            buf_clr     = 1'b1;
            first_blk_d = 1'b1;
            dig_valid_d = 1'b0;
            pad_pend_d  = 1'b0;
            state_d     = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE, ST_ABSORB, ST_DONE: begin
                    if (op_start) begin
                        buf_clr     = 1'b1;
                        buf_wr      = 1'b1;
                        first_blk_d = 1'b1;
                        dig_valid_d = 1'b0;
                        pad_pend_d  = 1'b0;
                        state_d     = ST_ABSORB;
                    end else if ((op_middle || op_end) && state_q == ST_ABSORB) begin
                        buf_wr = 1'b1;
                        if (wcnt == LAST_SLOT) begin
                            // block is full: fire it; an end then pads a fresh block
                            state_d    = ST_FIRE;
                            pad_pend_d = op_end;
                        end else if (op_end) begin
                            state_d = ST_PAD;
                        end
                    end else if (op_store) begin
                        if (state_q == ST_ABSORB) begin
                            cust_stall = 1'b1;
                        end else begin
                            cust_rf_we  = 1'b1;
                            cust_result = dig_valid_q ? dig_word : 32'h0;
                        end
                    end
                end
                ST_PAD: begin
                    cust_stall = op_known;
                    buf_pad    = 1'b1;
                    state_d    = ST_FIRE_LAST;
                end
                ST_FIRE, ST_FIRE_LAST: begin
                    cust_stall  = op_known;
                    core_start  = 1'b1;
                    core_init   = first_blk_q;
                    first_blk_d = 1'b0;
                    cnt_clr     = 1'b1;
                    state_d     = (state_q == ST_FIRE) ? ST_WAIT : ST_WAIT_LAST;
                end
                ST_WAIT: begin
                    cust_stall = op_known;
                    if (core_done) begin
                        buf_clr    = 1'b1;
                        pad_pend_d = 1'b0;
                        state_d    = pad_pend_q ? ST_PAD : ST_ABSORB;
                    end
                end
                ST_WAIT_LAST: begin
                    cust_stall = op_known;
                    if (core_done) begin
                        dig_valid_d = 1'b1;
                        state_d     = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            first_blk_q <= 1'b1;
            dig_valid_q <= 1'b0;
            pad_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            first_blk_q <= first_blk_d;
            dig_valid_q <= dig_valid_d;
            pad_pend_q  <= pad_pend_d;
        end
    end

endmodule

// File: tb/tb_or1200_keccak_cust5_unit.sv
// Bench for the l.cust5 Keccak unit with a fixed-latency core model and a
// message-level padding reference.
module tb_or1200_keccak_cust5_unit;

    localparam int RW        = 34;
    localparam int DW        = 16;
    localparam int BW        = 32 * RW;
    localparam int LAT       = 24;
    localparam int STALL_MAX = 400;

    localparam logic [4:0] OP_INIT   = 5'b00000;
    localparam logic [4:0] OP_START  = 5'b00100;
    localparam logic [4:0] OP_MIDDLE = 5'b00010;
    localparam logic [4:0] OP_END    = 5'b00001;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_BOGUS  = 5'b10000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cust_valid = 1'b0;
    logic [4:0]        cust_op = '0;
    logic [5:0]        cust_idx = '0;
    logic [31:0]       cust_opa = '0;
    logic              cust_stall, cust_rf_we;
    logic [31:0]       cust_result;
    logic              core_start, core_init;
    logic [BW-1:0]     core_block;
    logic              core_done = 1'b0;
    logic [32*DW-1:0]  core_digest = '0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_starts = 0;
    int lat_cnt  = 0;
    logic [BW-1:0] blk_log [32];
    logic          init_log [32];

    or1200_keccak_cust5_unit #(.RATE_WORDS(RW), .DIGEST_WORDS(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .cust_valid  (cust_valid),
        .cust_op     (cust_op),
        .cust_idx    (cust_idx),
        .cust_opa    (cust_opa),
        .cust_stall  (cust_stall),
        .cust_rf_we  (cust_rf_we),
        .cust_result (cust_result),
        .core_start  (core_start),
        .core_init   (core_init),
        .core_block  (core_block),
        .core_done   (core_done),
        .core_digest (core_digest)
    );

    always #5 clk = ~clk;

    function automatic logic [32*DW-1:0] rand_digest();
        logic [32*DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Core model: logs every absorbed block, answers LAT cycles later.
    always @(posedge clk) begin
        core_done <= 1'b0;
        if (core_start) begin
            blk_log[n_starts % 32]  <= core_block;
            init_log[n_starts % 32] <= core_init;
            n_starts <= n_starts + 1;
            lat_cnt  <= LAT;
        end else if (lat_cnt == 1) begin
            core_done   <= 1'b1;
            core_digest <= rand_digest();
            lat_cnt     <= 0;
        end else if (lat_cnt > 1) begin
            lat_cnt <= lat_cnt - 1;
        end
    end

    task automatic check(input string tag, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Reference: block b of message msg after pad10*1 over 32-bit LE words.
    function automatic logic [BW-1:0] exp_block(input logic [31:0] msg[$], input int b);
        int len = msg.size();
        int nblk = len / RW + 1;
        logic [BW-1:0] r = '0;
        logic [31:0] w;
        for (int k = 0; k < RW; k++) begin
            int p = b * RW + k;
            w = (p < len) ? msg[p] : 32'h0;
            if (p == len) w ^= 32'h0000_0001;
            if (b == nblk - 1 && k == RW - 1) w ^= 32'h8000_0000;
            r[k*32 +: 32] = w;
        end
        return r;
    endfunction

    // Present one instruction, hold it while stalled, report the accept cycle.
    task automatic issue(input logic [4:0] op, input logic [5:0] idx, input logic [31:0] opa,
                         output logic [31:0] res, output logic we, output int stalls);
        @(negedge clk);
        cust_valid = 1'b1;
        cust_op    = op;
        cust_idx   = idx;
        cust_opa   = opa;
        stalls     = 0;
        #1;
        while (cust_stall && stalls < STALL_MAX) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (cust_stall) check("stall_bound", 1, 0);
        res = cust_result;
        we  = cust_rf_we;
        @(posedge clk);
        #1;
        cust_valid = 1'b0;
        cust_op    = '0;
        cust_idx   = '0;
        cust_opa   = '0;
    endtask

    task automatic run_msg(input string name, input logic [31:0] msg[$], input bit bogus,
                           output int st34);
        logic [31:0] res;
        logic        we;
        int          st, base, nblk;
        base = n_starts;
        st34 = 0;
        nblk = msg.size() / RW + 1;
        issue(OP_START, 6'd0, msg[0], res, we, st);
        check($sformatf("%s start_stall", name), st, 0);
        if (bogus) begin
            issue(OP_BOGUS, 6'd3, $urandom, res, we, st);
            check($sformatf("%s bogus_we", name), we, 0);
            check($sformatf("%s bogus_stall", name), st, 0);
        end
        for (int i = 1; i < msg.size() - 1; i++) begin
            issue(OP_MIDDLE, 6'd0, msg[i], res, we, st);
            if (i == RW) st34 = st;
        end
        issue(OP_END, 6'd0, msg[msg.size()-1], res, we, st);
        issue(OP_STORE, 6'd0, 32'h0, res, we, st);
        check($sformatf("%s store_stalled", name), st > 0, 1);
        check($sformatf("%s store_we", name), we, 1);
        check($sformatf("%s store_res", name), res, core_digest[31:0]);
        check($sformatf("%s nblocks", name), n_starts - base, nblk);
        for (int b = 0; b < nblk; b++) begin
            check($sformatf("%s blk%0d", name, b), blk_log[(base + b) % 32], exp_block(msg, b));
            check($sformatf("%s init%0d", name, b), init_log[(base + b) % 32], b == 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] m[$];
        logic [31:0] res;
        logic        we;
        logic [BW-1:0] lastpad;
        int          st, st34, base;

        // reset state
        #12;
        check("rst_start", core_start, 0);
        check("rst_init", core_init, 0);
        check("rst_stall", cust_stall, 0);
        check("rst_we", cust_rf_we, 0);
        check("rst_result", cust_result, 0);
        check("rst_block", core_block, 0);
        @(negedge clk);
        rst = 1'b1;

        // 1: short message 1..7
        m = {};
        for (int i = 1; i <= 7; i++) m.push_back(32'(i));
        base = n_starts;
        run_msg("t1", m, 1'b0, st34);
        check("t1 word7", blk_log[base % 32][7*32 +: 32], 32'h0000_0001);
        check("t1 word33", blk_log[base % 32][33*32 +: 32], 32'h8000_0000);

        // 2: digest readback in DONE
        for (int i = 0; i < DW; i++) begin
            issue(OP_STORE, 6'(i), 32'h0, res, we, st);
            check($sformatf("t2 we%0d", i), we, 1);
            check($sformatf("t2 stall%0d", i), st, 0);
            check($sformatf("t2 res%0d", i), res, core_digest[i*32 +: 32]);
        end
        issue(OP_STORE, 6'd20, 32'h0, res, we, st);
        check("t2 idx20_res", res, 0);
        check("t2 idx20_we", we, 1);
        issue(OP_MIDDLE, 6'd0, 32'hdead_beef, res, we, st);
        check("t2 mid_done_stall", st, 0);
        check("t2 mid_done_we", we, 0);
        issue(OP_STORE, 6'd5, 32'h0, res, we, st);
        check("t2 after_mid", res, core_digest[5*32 +: 32]);

        // 3: 36-word message spanning two blocks
        m = {};
        for (int i = 0; i < 36; i++) m.push_back($urandom);
        run_msg("t3", m, 1'b0, st34);
        check("t3 mid34_stalled", st34 > 0, 1);

        // 4: exactly one full block, pad goes to a fresh block
        m = {};
        for (int i = 0; i < RW; i++) m.push_back($urandom);
        base = n_starts;
        run_msg("t4", m, 1'b0, st34);
        lastpad = '0;
        lastpad[31:0] = 32'h0000_0001;
        lastpad[33*32 +: 32] = 32'h8000_0000;
        check("t4 padblock", blk_log[(base + 1) % 32], lastpad);

        // 5: init while the core is busy
        base = n_starts;
        issue(OP_START, 6'd0, $urandom, res, we, st);
        for (int i = 1; i < RW; i++) issue(OP_MIDDLE, 6'd0, $urandom, res, we, st);
        issue(OP_INIT, 6'd0, 32'h0, res, we, st);
        check("t5 init_stalled", st > 0, 1);
        check("t5 one_start", n_starts - base, 1);
        issue(OP_STORE, 6'd0, 32'h0, res, we, st);
        check("t5 store_stall", st, 0);
        check("t5 store_we", we, 1);
        check("t5 store_res", res, 0);
        m = {};
        for (int i = 0; i < 3; i++) m.push_back($urandom);
        run_msg("t5b", m, 1'b0, st34);

        // 6: asynchronous reset while waiting on the last block
        issue(OP_START, 6'd0, $urandom, res, we, st);
        for (int i = 0; i < 3; i++) issue(OP_MIDDLE, 6'd0, $urandom, res, we, st);
        issue(OP_END, 6'd0, $urandom, res, we, st);
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("t6 start", core_start, 0);
        check("t6 init", core_init, 0);
        check("t6 stall", cust_stall, 0);
        check("t6 block", core_block, 0);
        @(negedge clk);
        rst = 1'b1;
        repeat (LAT + 10) @(negedge clk);
        issue(OP_STORE, 6'd0, 32'h0, res, we, st);
        check("t6 store_stall", st, 0);
        check("t6 store_we", we, 1);
        check("t6 store_res", res, 0);
        check("t6 block_after", core_block, 0);

        // randomized messages
        for (int r = 0; r < 4; r++) begin
            int len = $urandom_range(2, 75);
            m = {};
            for (int i = 0; i < len; i++) m.push_back($urandom);
            run_msg($sformatf("rnd%0d", r), m, 1'b1, st34);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
